// File: rtl/stack_sequencer.sv
// stack_sequencer
//   Instruction-side driver for the stack register file of the single-cycle
//   stack CPU. Accepts one stack-machine instruction per valid/ready handshake
//   and turns it into the pop/push enable pattern of the stack file. It also
//   computes ALU results from the two top-of-stack operands and emits values
//   popped by OUT on an output handshake.
//
//   Stack-file enable contract ({stk_en1,stk_en2,stk_we}):
//     100 pop 1, 110 pop 2, 111 pop 2 then push, 101 replace top,
//     001 push, 000 no change.
//
//   Optional feature: define STACK_SEQ_CHECK_EN to add a depth counter with
//   underflow/overflow detection. Without it, err is raised only by illegal
//   opcodes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake
//   instr_op [3:0]           opcode (0..10 legal, 11..15 illegal)
//   instr_imm [DBITS]        immediate for PUSH
//   stk_en1/en2/we, stk_din  stack file enables and push data
//   stk_dout1/stk_dout2      top / second stack entry (combinational)
//   out_valid/out_ready      output handshake for OUT
//   out_data [DBITS]         value popped by OUT
//   err                      sticky error flag
module stack_sequencer #(
    parameter int DBITS = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [DBITS-1:0] instr_imm,
    output logic             stk_en1,
    output logic             stk_en2,
    output logic             stk_we,
    output logic [DBITS-1:0] stk_din,
    input  logic [DBITS-1:0] stk_dout1,
    input  logic [DBITS-1:0] stk_dout2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DBITS-1:0] out_data,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE, SWAP_B, SWAP_A, DUP_2, OUT_WAIT, ERR
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_DUP  = 4'd8;
    localparam logic [3:0] OP_SWAP = 4'd9;
    localparam logic [3:0] OP_OUT  = 4'd10;

    state_t           state_q, state_d;
    logic [DBITS-1:0] a_q, a_d;          // DUP value / SWAP old top
    logic [DBITS-1:0] b_q, b_d;          // SWAP old second
    logic [DBITS-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic             fault;

`ifdef STACK_SEQ_CHECK_EN
    localparam int DW = $clog2(DEPTH + 1);
    logic [DW-1:0] depth_q, depth_d;

    // Every enable pattern of the contract nets out as +we -en1 -en2.
    assign depth_d = depth_q + DW'(stk_we) - DW'(stk_en1) - DW'(stk_en2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) depth_q <= '0;
        else     depth_q <= depth_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        instr_ready = 1'b0;
        stk_en1     = 1'b0;
        stk_en2     = 1'b0;
        stk_we      = 1'b0;
        stk_din     = '0;
        fault       = 1'b0;

        case (state_q)
            IDLE: begin
                instr_ready = !out_valid_q;
                if (instr_valid && instr_ready) begin
                    fault = (instr_op > OP_OUT);
`ifdef STACK_SEQ_CHECK_EN
                    case (instr_op)
                        OP_POP, OP_OUT, OP_DUP:
                            if (depth_q == '0) fault = 1'b1;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SWAP:
                            if (depth_q < DW'(2)) fault = 1'b1;
                        default: ;
                    endcase
                    if ((instr_op == OP_PUSH || instr_op == OP_DUP) &&
                        depth_q == DW'(DEPTH))
                        fault = 1'b1;
`endif
                    if (fault) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        case (instr_op)
                            OP_PUSH: begin
                                stk_we  = 1'b1;
                                stk_din = instr_imm;
                            end
                            OP_POP: stk_en1 = 1'b1;
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                {stk_en1, stk_en2, stk_we} = 3'b111;
                                case (instr_op)
                                    OP_ADD:  stk_din = stk_dout2 + stk_dout1;
                                    OP_SUB:  stk_din = stk_dout2 - stk_dout1;
                                    OP_AND:  stk_din = stk_dout2 & stk_dout1;
                                    OP_OR:   stk_din = stk_dout2 | stk_dout1;
                                    default: stk_din = stk_dout2 ^ stk_dout1;
                                endcase
                            end
                            OP_DUP: begin
                                // Replace top with itself, push the copy next cycle.
                                stk_en1 = 1'b1;
                                stk_we  = 1'b1;
                                stk_din = stk_dout1;
                                a_d     = stk_dout1;
                                state_d = DUP_2;
                            end
                            OP_SWAP: begin
                                // Pop both, then push back old top first so
                                // the old second ends up on top.
                                stk_en1 = 1'b1;
                                stk_en2 = 1'b1;
                                a_d     = stk_dout1;
                                b_d     = stk_dout2;
                                state_d = SWAP_B;
                            end
                            OP_OUT: begin
                                stk_en1     = 1'b1;
                                out_data_d  = stk_dout1;
                                out_valid_d = 1'b1;
                                state_d     = OUT_WAIT;
                            end
                            default: ; // NOP
                        endcase
                    end
                end
            end
            DUP_2: begin
                stk_we  = 1'b1;
                stk_din = a_q;
                state_d = IDLE;
            end
            SWAP_B: begin
                stk_we  = 1'b1;
                stk_din = a_q;
                state_d = SWAP_A;
            end
            SWAP_A: begin
                stk_we  = 1'b1;
                stk_din = b_q;
                state_d = IDLE;
            end
            OUT_WAIT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ; // ERR: absorbing until reset
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule
